// File: rtl/clock_enable_pkg.sv
// Shared constants, config struct and helpers for the clock-enable generator.
package clock_enable_pkg;

  localparam int unsigned CFG_W    = 28;
  localparam int unsigned DEF_DIV  = 4;
  localparam int unsigned DEF_HIGH = 1;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } cfg_t;

  // A zero period is meaningless; treat it as divide-by-one.
  function automatic logic [CFG_W-1:0] sanitize_div(input logic [CFG_W-1:0] div);
    return (div == '0) ? CFG_W'(1) : div;
  endfunction

endpackage

// File: rtl/clock_enable_channel.sv
// One divider channel: counter, active/shadow period registers and registered outputs.
module clock_enable_channel
  import clock_enable_pkg::*;
#(
  parameter int unsigned CNT_W        = CFG_W,
  parameter int unsigned DEFAULT_DIV  = DEF_DIV,
  parameter int unsigned DEFAULT_HIGH = DEF_HIGH
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  input  logic load,
  input  cfg_t cfg,
  output logic pending,
  output logic clock_out,
  output logic tick_out
);

  localparam logic [CNT_W-1:0] RstDiv  = (DEFAULT_DIV == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RstHigh = CNT_W'(DEFAULT_HIGH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] high_act_q, high_act_d;
  logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
  logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
  logic             pending_q, pending_d;
  logic             clock_q, clock_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic [CFG_W-1:0] load_div;

  // div_act is never zero, so the subtraction cannot underflow.
  assign wrap     = cnt_q >= (div_act_q - CNT_W'(1));
  assign load_div = sanitize_div(cfg.div);

  always_comb begin
    cnt_d         = cnt_q;
    div_act_d     = div_act_q;
    high_act_d    = high_act_q;
    shadow_div_d  = shadow_div_q;
    shadow_high_d = shadow_high_q;
    pending_d     = pending_q;
    clock_d       = 1'b0;
    tick_d        = 1'b0;

    if (enable) begin
      clock_d = cnt_q < high_act_q;
      tick_d  = cnt_q == '0;
      cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap && pending_q) begin
        div_act_d  = shadow_div_q;
        high_act_d = shadow_high_q;
        pending_d  = 1'b0;
      end
    end

    if (restart) begin
      cnt_d = '0;
      if (pending_q) begin
        div_act_d  = shadow_div_q;
        high_act_d = shadow_high_q;
        pending_d  = 1'b0;
      end
    end

    // A load never meets a pending channel, so it only ever lands in an idle shadow.
    if (load) begin
      shadow_div_d  = CNT_W'(load_div);
      shadow_high_d = CNT_W'(cfg.high);
      pending_d     = 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      div_act_q     <= RstDiv;
      high_act_q    <= RstHigh;
      shadow_div_q  <= RstDiv;
      shadow_high_q <= RstHigh;
      pending_q     <= 1'b0;
      clock_q       <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      div_act_q     <= div_act_d;
      high_act_q    <= high_act_d;
      shadow_div_q  <= shadow_div_d;
      shadow_high_q <= shadow_high_d;
      pending_q     <= pending_d;
      clock_q       <= clock_d;
      tick_q        <= tick_d;
    end
  end

  assign pending   = pending_q;
  assign clock_out = clock_q;
  assign tick_out  = tick_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator with a valid/ready config port.
module clock_enable_gen
  import clock_enable_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = CFG_W,
  parameter int unsigned DEFAULT_DIV  = DEF_DIV,
  parameter int unsigned DEFAULT_HIGH = DEF_HIGH,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick_out
);

  cfg_t              cfg;
  logic [NUM_CH-1:0] load;

  always_comb begin
    cfg.div  = CFG_W'(cfg_div);
    cfg.high = CFG_W'(cfg_high);
  end

  // Out-of-range channels fall through with ready high and no load strobe.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~cfg_pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

    clock_enable_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_ch (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable),
      .restart   (sync_restart),
      .load      (load[g]),
      .cfg       (cfg),
      .pending   (cfg_pending[g]),
      .clock_out (clock_out[g]),
      .tick_out  (tick_out[g])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized bench for clock_enable_gen against a per-channel phase model.
module tb_clock_enable_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 28;
  localparam int CH_W   = 2;

  logic              clock_in = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              sync_restart;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_high;
  logic [NUM_CH-1:0] cfg_pending;
  logic [NUM_CH-1:0] clock_out;
  logic [NUM_CH-1:0] tick_out;

  clock_enable_gen #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_DIV  (4),
    .DEFAULT_HIGH (1)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .sync_restart (sync_restart),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .cfg_pending  (cfg_pending),
    .clock_out    (clock_out),
    .tick_out     (tick_out)
  );

  always #5 clock_in = ~clock_in;

  int checks   = 0;
  int failures = 0;

  // Model: position within the running period plus the period/high pair in force.
  int unsigned       pos     [NUM_CH];
  int unsigned       period  [NUM_CH];
  int unsigned       on_len  [NUM_CH];
  int unsigned       nxt_per [NUM_CH];
  int unsigned       nxt_on  [NUM_CH];
  logic [NUM_CH-1:0] exp_pend;
  logic [NUM_CH-1:0] exp_clk;
  logic [NUM_CH-1:0] exp_tick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready();
    if (int'(cfg_ch) >= NUM_CH) return 1'b1;
    return ~exp_pend[cfg_ch];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      pos[c] = 0; period[c] = 4; on_len[c] = 1; nxt_per[c] = 4; nxt_on[c] = 1;
    end
    exp_pend = '0; exp_clk = '0; exp_tick = '0;
  endtask

  task automatic take_new(input int c);
    period[c] = nxt_per[c];
    on_len[c] = nxt_on[c];
    exp_pend[c] = 1'b0;
    pos[c] = 0;
  endtask

  // Called at each rising edge with the inputs that were stable across it.
  task automatic model_step();
    logic xfer;
    bit   last;
    xfer = cfg_valid && exp_ready();
    for (int c = 0; c < NUM_CH; c++) begin
      last = (pos[c] + 1 >= period[c]);
      if (enable) begin
        exp_clk[c]  = (pos[c] < on_len[c]);
        exp_tick[c] = (pos[c] == 0);
        pos[c] = last ? 0 : pos[c] + 1;
        if (last && exp_pend[c]) take_new(c);
      end else begin
        exp_clk[c]  = 1'b0;
        exp_tick[c] = 1'b0;
      end
      if (sync_restart) begin
        pos[c] = 0;
        if (exp_pend[c]) take_new(c);
      end
      if (xfer && int'(cfg_ch) == c) begin
        nxt_per[c]  = (cfg_div == 0) ? 1 : int'(cfg_div);
        nxt_on[c]   = int'(cfg_high);
        exp_pend[c] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string phase);
    check_eq({phase, " clock_out"}, 32'(clock_out), 32'(exp_clk));
    check_eq({phase, " tick_out"}, 32'(tick_out), 32'(exp_tick));
    check_eq({phase, " cfg_pending"}, 32'(cfg_pending), 32'(exp_pend));
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = '0;
    cfg_div      = '0;
    cfg_high     = '0;
    model_reset();
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    reset_n = 1'b1;
    #1;
    check_outputs("reset");
    check_eq("reset cfg_ready", 32'(cfg_ready), 32'd1);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async reset");
        @(negedge clock_in);
        reset_n = 1'b1;
      end

      if (cyc < 12) begin
        enable = 1'b1; sync_restart = 1'b0; cfg_valid = 1'b0;
      end else begin
        enable       = ($urandom_range(0, 9) != 0);
        sync_restart = ($urandom_range(0, 29) == 0);
        cfg_valid    = ($urandom_range(0, 2) == 0);
        cfg_ch       = CH_W'($urandom_range(0, 3));
        cfg_div      = CNT_W'($urandom_range(0, 9));
        cfg_high     = CNT_W'($urandom_range(0, 11));
      end
      #1;
      check_eq("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));

      @(posedge clock_in);
      model_step();
      @(negedge clock_in);
      check_outputs("run");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Multi-channel, runtime-programmable clock-enable/duty-cycle generator. Next generation of the fixed-divisor divider.
- Each channel divides clock_in by a programmable period and asserts its output for a programmable high count. It also emits a one-cycle tick at each period start.
- New periods and high counts are loaded through a valid/ready config port and take effect glitch-free at the channel's period boundary.
- Feeds the CNN datapath (dense, maxpool, conv stages) with stage-rate enables, so no derived clocks are needed.

Parameters:
- NUM_CH, 2, number of independent channels (1..16).
- CNT_W, 28, counter, period and high-count width.
- DEFAULT_DIV, 4, period loaded at reset into every channel.
- DEFAULT_HIGH, 1, high count loaded at reset into every channel.
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel index width (derived; do not override).

Ports:
- clock_in, input, 1, sole clock; all logic on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, global run; low freezes all counters.
- sync_restart, input, 1, one-cycle pulse that realigns all channels to phase 0.
- cfg_valid, input, 1, config request.
- cfg_ready, output, 1, config accept (combinational: ~pending[cfg_ch]).
- cfg_ch, input, CH_W, target channel.
- cfg_div, input, CNT_W, new period in clock_in cycles.
- cfg_high, input, CNT_W, new high count.
- cfg_pending, output, NUM_CH, per-channel shadow-loaded-not-yet-applied flag.
- clock_out, output, NUM_CH, per-channel duty-cycle waveform (registered).
- tick_out, output, NUM_CH, per-channel one-cycle period-start pulse (registered).

Behaviour:
- Reset (async assert, sync release), per channel: cnt=0, div_act=DEFAULT_DIV, high_act=DEFAULT_HIGH, shadows=defaults, pending=0, clock_out=0, tick_out=0. cfg_ready=1 after reset.
- Counter, per channel, when enable=1:
  - cnt <= (cnt >= div_act-1) ? 0 : cnt+1.
  - The ">=" compare guarantees recovery if a stale cnt exceeds a new, smaller period.
- Outputs, when enable=1:
  - clock_out <= (cnt < high_act).
  - tick_out <= (cnt == 0).
  - Latency is one cycle from counter to output.
- enable=0: cnt, div_act and high_act hold; clock_out and tick_out forced to 0 on the next edge. Resuming continues from the held cnt.
- Period arithmetic:
  - cfg_div=0 is stored as 1.
  - div_act=1 gives tick_out=1 every enabled cycle and clock_out=(high_act>=1).
  - high_act=0 gives clock_out constantly 0.
  - high_act >= div_act gives clock_out constantly 1 while enabled.
- Config handshake:
  - Transfer occurs on cfg_valid & cfg_ready at a rising edge.
  - Transfer writes shadow_div/shadow_high[cfg_ch] and sets pending[cfg_ch].
  - cfg_ready is low while the addressed channel is pending. Other channels remain writable.
  - cfg_ch >= NUM_CH: cfg_ready=1, transfer accepted and discarded, no state change.
- Apply, per channel, on the enabled wrap edge (cnt >= div_act-1 and enable=1) with pending=1: div_act/high_act <= shadows, pending <= 0, cnt <= 0.
- Wrap and transfer in the same cycle: impossible for the same channel, because cfg_ready=0 while pending. Applying one channel never blocks transfers to others.
- sync_restart=1, regardless of enable:
  - All cnt <= 0.
  - Every pending channel applies its shadows and clears pending.
  - Outputs on that edge still reflect the pre-restart cnt. A transfer in the same cycle lands in the shadow and applies at the next wrap.
- Reset mid-period or mid-handshake: everything returns to defaults; an in-flight transfer is lost.

Decomposition:
- Package clock_enable_pkg:
  - CNT_W default and DEFAULT_DIV/DEFAULT_HIGH constants.
  - Packed config struct {div, high}.
  - Function sanitize_div (0 -> 1).
- Sub-module clock_enable_channel, one instance per channel via generate, containing:
  - counter, active and shadow registers, pending flag and output regs.
  - Inputs: enable, restart, load strobe and cfg struct.
  - Outputs: pending, clock_out and tick_out.
- The top holds channel decode, cfg_ready mux and out-of-range discard.

Test Plan:
- Reset defaults: reset_n released, enable=1 for 12 cycles -> clock_out[0] = 1,0,0,0 repeating; tick_out[0] coincident with each 1; cfg_ready=1.
- Reprogram mid-period: at cnt=1 write ch0 div=6 high=3 -> cfg_pending[0]=1 and cfg_ready low for ch0 until wrap (2 cycles later); the following period shows 1,1,1,0,0,0; ch1 is unaffected and remains writable.
- Edge values: div=0 -> tick_out every cycle and clock_out=1 (high=1); high=0 -> clock_out=0; high=10 with div=5 -> clock_out stuck 1 with tick every 5.
- enable gating: drop enable for 7 cycles at cnt=2 with div=4 -> outputs 0 and cnt frozen; after re-enable the next tick arrives exactly 2 enabled cycles later.
- sync_restart: ch0 div=4 and ch1 div=6 at differing phases with ch1 pending div=3 -> after the pulse both tick together; ch1 runs period 3 immediately; cfg_pending=0.
- Handshake corners: cfg_valid held with cfg_ch=3 (NUM_CH=2) -> accepted, no state change; a back-to-back write to a pending channel stalls (cfg_ready=0) until its wrap, then is accepted.
